motor_control_nch: RTL and testbench

MOTOR_CONTROL_NCH -- requirements
Module: motor_control_nch

---
 rtl/motor_control_nch.sv | 260 ++++++++++++++++++++++++++
 tb/tb_motor_control_nch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_control_nch.sv
// ---------------------------------------------------------------------------
// motor_control_nch -- multi-channel motor duty / RPM setpoint controller
//
// A shared FSM (DISABLED / SOFT_START / RUN / SOFT_STOP) sequences NUM_CH
// identical channels. Each channel ramps its RPM setpoint toward
// base_rpm + clamped per-channel offset on clk_en_adc, and applies a signed
// duty correction on clk_en_tach. In SOFT_STOP both registers ramp to zero.
//
// Optional build macro: MOTOR_SLEW_LIMIT_EN
//   When defined, each duty correction is clamped to +/-MAX_DUTY_STEP before
//   it is applied. When undefined, the correction is applied unclamped.
//
// Ports
//   clk                clock, all logic on rising edge
//   reset              synchronous, active-high
//   clk_en_tach        duty-update strobe
//   clk_en_adc         setpoint-update strobe
//   en                 run request
//   duty_cycle_offset  NUM_CH x (PWM_RESOLUTION+1) signed duty corrections
//   base_rpm           common unsigned RPM target
//   rpm_offset         NUM_CH x (RPM_RESOLUTION+1) signed RPM offsets
//   duty_cycle         NUM_CH x PWM_RESOLUTION registered duty
//   rpm_setpoint       NUM_CH x RPM_RESOLUTION registered setpoint
//   state              00 DISABLED, 01 SOFT_START, 10 RUN, 11 SOFT_STOP
// ---------------------------------------------------------------------------

// Per-channel datapath: target computation, setpoint ramp, duty update.
module motor_ch #(
   parameter int PWM_RESOLUTION   = 16,
   parameter int RPM_RESOLUTION   = 16,
   parameter int MAX_RPM_OFFSET   = 50,
   parameter int RPM_RAMP_STEP    = 10,
   parameter int MAX_DUTY_STEP    = 256,
   parameter int DUTY_CYCLE_LIMIT = ((2**PWM_RESOLUTION-1)*3)/4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      run_mode,   // SOFT_START or RUN
   input  logic                      stop_mode,  // SOFT_STOP
   input  logic                      dis_mode,   // DISABLED
   input  logic                      clk_en_tach,
   input  logic                      clk_en_adc,
   input  logic [PWM_RESOLUTION:0]   duty_offset,
   input  logic [RPM_RESOLUTION-1:0] base_rpm,
   input  logic [RPM_RESOLUTION:0]   rpm_offset,
   output logic [PWM_RESOLUTION-1:0] duty,
   output logic [RPM_RESOLUTION-1:0] setpoint,
   output logic                      at_target,
   output logic                      is_zero
);
   localparam int P = PWM_RESOLUTION;
   localparam int R = RPM_RESOLUTION;

   localparam logic signed [R:0]   ROFS_HI = (R+1)'(MAX_RPM_OFFSET);
   localparam logic signed [R:0]   ROFS_LO = -ROFS_HI;
   localparam logic [R-1:0]        RSTEP   = R'(RPM_RAMP_STEP);
   localparam logic [P-1:0]        DSTEP   = P'(MAX_DUTY_STEP);
   localparam logic signed [P+1:0] DLIM    = (P+2)'(DUTY_CYCLE_LIMIT);

   // ---------------- RPM target ----------------
   logic signed [R:0]   rpm_ofs_s;
   logic signed [R:0]   rpm_ofs_c;
   logic signed [R+1:0] rpm_sum;
   logic [R-1:0]        target;

   assign rpm_ofs_s = rpm_offset;

   always_comb begin
      rpm_ofs_c = rpm_ofs_s;
      if (rpm_ofs_s > ROFS_HI)
         rpm_ofs_c = ROFS_HI;
      else if (rpm_ofs_s < ROFS_LO)
         rpm_ofs_c = ROFS_LO;
   end

   // Two guard bits: MSB flags a negative sum, bit R flags overflow above
   // the unsigned range, so saturation needs no wide compares.
   assign rpm_sum = $signed({2'b00, base_rpm}) + (R+2)'(rpm_ofs_c);

   always_comb begin
      target = rpm_sum[R-1:0];
      if (rpm_sum[R+1])
         target = '0;
      else if (rpm_sum[R])
         target = '1;
   end

   // ---------------- setpoint ramp ----------------
   logic [R-1:0] sp_ramp;
   logic [R-1:0] sp_down;

   always_comb begin
      sp_ramp = setpoint;
      if (target > setpoint)
         sp_ramp = (target - setpoint > RSTEP) ? setpoint + RSTEP : target;
      else if (target < setpoint)
         sp_ramp = (setpoint - target > RSTEP) ? setpoint - RSTEP : target;
   end

   assign sp_down = (setpoint > RSTEP) ? setpoint - RSTEP : '0;

   // ---------------- duty update ----------------
   logic signed [P:0]   doff_s;
   logic signed [P:0]   eff_ofs;
   logic signed [P+1:0] duty_sum;
   logic [P-1:0]        duty_upd;
   logic [P-1:0]        duty_down;

   assign doff_s = duty_offset;

`ifdef MOTOR_SLEW_LIMIT_EN
   localparam logic signed [P:0] DOFS_HI = (P+1)'(MAX_DUTY_STEP);
   localparam logic signed [P:0] DOFS_LO = -DOFS_HI;

   always_comb begin
      eff_ofs = doff_s;
      if (doff_s > DOFS_HI)
         eff_ofs = DOFS_HI;
      else if (doff_s < DOFS_LO)
         eff_ofs = DOFS_LO;
   end
`else
   assign eff_ofs = doff_s;
`endif

   assign duty_sum = $signed({2'b00, duty}) + (P+2)'(eff_ofs);

   always_comb begin
      duty_upd = duty_sum[P-1:0];
      if (duty_sum[P+1])
         duty_upd = '0;
      else if (duty_sum > DLIM)
         duty_upd = DLIM[P-1:0];
   end

   assign duty_down = (duty > DSTEP) ? duty - DSTEP : '0;

   // ---------------- registers ----------------
   // Strobes are independent: both register sets may update in one cycle.
   always_ff @(posedge clk) begin
      if (reset || dis_mode) begin
         duty     <= '0;
         setpoint <= '0;
      end else begin
         if (clk_en_adc) begin
            if (run_mode)
               setpoint <= sp_ramp;
            else if (stop_mode)
               setpoint <= sp_down;
         end
         if (clk_en_tach) begin
            if (run_mode)
               duty <= duty_upd;
            else if (stop_mode)
               duty <= duty_down;
         end
      end
   end

   assign at_target = (setpoint == target);
   assign is_zero   = (setpoint == '0) && (duty == '0);
endmodule

// Top: shared sequencing FSM plus an array of channel datapaths.
module motor_control_nch #(
   parameter int NUM_CH           = 2,
   parameter int PWM_RESOLUTION   = 16,
   parameter int RPM_RESOLUTION   = 16,
   parameter int MAX_RPM_OFFSET   = 50,
   parameter int RPM_RAMP_STEP    = 10,
   parameter int MAX_DUTY_STEP    = 256,
   parameter int DUTY_CYCLE_LIMIT = ((2**PWM_RESOLUTION-1)*3)/4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 clk_en_tach,
   input  logic                                 clk_en_adc,
   input  logic                                 en,
   input  logic [NUM_CH*(PWM_RESOLUTION+1)-1:0] duty_cycle_offset,
   input  logic [RPM_RESOLUTION-1:0]            base_rpm,
   input  logic [NUM_CH*(RPM_RESOLUTION+1)-1:0] rpm_offset,
   output logic [NUM_CH*PWM_RESOLUTION-1:0]     duty_cycle,
   output logic [NUM_CH*RPM_RESOLUTION-1:0]     rpm_setpoint,
   output logic [1:0]                           state
);
   typedef enum logic [1:0] {
      DISABLED   = 2'b00,
      SOFT_START = 2'b01,
      RUN        = 2'b10,
      SOFT_STOP  = 2'b11
   } state_t;

   state_t state_q, state_d;

   logic [NUM_CH-1:0] at_target;
   logic [NUM_CH-1:0] is_zero;
   logic              run_mode, stop_mode, dis_mode;

   assign run_mode  = (state_q == SOFT_START) || (state_q == RUN);
   assign stop_mode = (state_q == SOFT_STOP);
   assign dis_mode  = (state_q == DISABLED);

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= DISABLED;
      else
         state_q <= state_d;
   end

   // Completion checks look at registered values, so RUN / DISABLED are
   // entered the cycle after the last register reaches its final value.
   always_comb begin
      state_d = state_q;
      case (state_q)
         DISABLED:   if (en) state_d = SOFT_START;
         SOFT_START: begin
            if (!en)
               state_d = SOFT_STOP;
            else if (&at_target)
               state_d = RUN;
         end
         RUN:        if (!en) state_d = SOFT_STOP;
         SOFT_STOP: begin
            if (en)
               state_d = SOFT_START;
            else if (&is_zero)
               state_d = DISABLED;
         end
         default:    state_d = DISABLED;
      endcase
   end

   assign state = state_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      motor_ch #(
         .PWM_RESOLUTION  (PWM_RESOLUTION),
         .RPM_RESOLUTION  (RPM_RESOLUTION),
         .MAX_RPM_OFFSET  (MAX_RPM_OFFSET),
         .RPM_RAMP_STEP   (RPM_RAMP_STEP),
         .MAX_DUTY_STEP   (MAX_DUTY_STEP),
         .DUTY_CYCLE_LIMIT(DUTY_CYCLE_LIMIT)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .run_mode   (run_mode),
         .stop_mode  (stop_mode),
         .dis_mode   (dis_mode),
         .clk_en_tach(clk_en_tach),
         .clk_en_adc (clk_en_adc),
         .duty_offset(duty_cycle_offset[i*(PWM_RESOLUTION+1) +: PWM_RESOLUTION+1]),
         .base_rpm   (base_rpm),
         .rpm_offset (rpm_offset[i*(RPM_RESOLUTION+1) +: RPM_RESOLUTION+1]),
         .duty       (duty_cycle[i*PWM_RESOLUTION +: PWM_RESOLUTION]),
         .setpoint   (rpm_setpoint[i*RPM_RESOLUTION +: RPM_RESOLUTION]),
         .at_target  (at_target[i]),
         .is_zero    (is_zero[i])
      );
   end
endmodule

// File: tb/tb_motor_control_nch.sv
// ---------------------------------------------------------------------------
// tb_motor_control_nch -- directed self-checking bench for motor_control_nch
// (NUM_CH=2, 16-bit widths, default limits; duty ceiling 49151).
// Expected values are hand-derived; duty pre-positioning uses steps of at
// most 256 so the sequence is valid with or without MOTOR_SLEW_LIMIT_EN.
// ---------------------------------------------------------------------------
module tb_motor_control_nch;
   localparam int P = 16;
   localparam int R = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              clk_en_tach;
   logic              clk_en_adc;
   logic              en;
   logic [2*(P+1)-1:0] duty_cycle_offset;
   logic [R-1:0]      base_rpm;
   logic [2*(R+1)-1:0] rpm_offset;
   logic [2*P-1:0]    duty_cycle;
   logic [2*R-1:0]    rpm_setpoint;
   logic [1:0]        state;

   int n_chk  = 0;
   int n_fail = 0;
   int m0, m1;   // bench model of current duties

   motor_control_nch #(.NUM_CH(2), .PWM_RESOLUTION(P), .RPM_RESOLUTION(R)) dut (
      .clk              (clk),
      .reset            (reset),
      .clk_en_tach      (clk_en_tach),
      .clk_en_adc       (clk_en_adc),
      .en               (en),
      .duty_cycle_offset(duty_cycle_offset),
      .base_rpm         (base_rpm),
      .rpm_offset       (rpm_offset),
      .duty_cycle       (duty_cycle),
      .rpm_setpoint     (rpm_setpoint),
      .state            (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      n_chk++;
      assert (obs === 32'(exp)) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input bit t, input bit a);
      clk_en_tach = t;
      clk_en_adc  = a;
      step();
      clk_en_tach = 1'b0;
      clk_en_adc  = 1'b0;
   endtask

   task automatic set_doff(input int o0, input int o1);
      logic [P:0] a, b;
      a = o0[P:0];
      b = o1[P:0];
      duty_cycle_offset = {b, a};
   endtask

   task automatic set_rofs(input int o0, input int o1);
      logic [R:0] a, b;
      a = o0[R:0];
      b = o1[R:0];
      rpm_offset = {b, a};
   endtask

   function automatic int lim256(input int d);
      if (d > 256) return 256;
      if (d < -256) return -256;
      return d;
   endfunction

   // Move both duties to the given values with corrections of at most 256.
   task automatic drive_to(input int t0, input int t1);
      int o0, o1;
      while (m0 != t0 || m1 != t1) begin
         o0 = lim256(t0 - m0);
         o1 = lim256(t1 - m1);
         set_doff(o0, o1);
         tick(1'b1, 1'b0);
         m0 += o0;
         m1 += o1;
      end
      set_doff(0, 0);
   endtask

   function automatic int d0(); return int'(duty_cycle[P-1:0]); endfunction
   function automatic int d1(); return int'(duty_cycle[2*P-1:P]); endfunction
   function automatic int s0(); return int'(rpm_setpoint[R-1:0]); endfunction
   function automatic int s1(); return int'(rpm_setpoint[2*R-1:R]); endfunction

   initial begin
      // Reset overrides en and strobes.
      reset = 1'b1; en = 1'b1; clk_en_tach = 1'b1; clk_en_adc = 1'b1;
      base_rpm = 16'd100; set_doff(500, 500); set_rofs(0, 0);
      step(); step();
      chk("rst_state", state, 0);
      chk("rst_duty", duty_cycle, 0);
      chk("rst_sp", rpm_setpoint, 0);

      // Soft start ramp: targets 80 / 120.
      reset = 1'b0; clk_en_tach = 1'b0; clk_en_adc = 1'b0; set_doff(0, 0);
      set_rofs(-20, 20);
      step();
      chk("start_state", state, 1);
      tick(1'b0, 1'b1);
      chk("ramp1_sp0", s0(), 10);
      chk("ramp1_sp1", s1(), 10);
      for (int i = 2; i <= 8; i++) tick(1'b0, 1'b1);
      chk("ramp8_sp0", s0(), 80);
      for (int i = 9; i <= 12; i++) tick(1'b0, 1'b1);
      chk("ramp12_sp0", s0(), 80);
      chk("ramp12_sp1", s1(), 120);
      chk("ramp12_state", state, 1);
      step();
      chk("run_state", state, 2);

      // Duty correction and clamping.
      m0 = 0; m1 = 0;
      drive_to(1000, 1000);
      chk("duty1000_0", d0(), 1000);
      chk("duty1000_1", d1(), 1000);
      set_doff(5000, 0);
      tick(1'b1, 1'b0);
`ifdef MOTOR_SLEW_LIMIT_EN
      chk("duty_plus5000", d0(), 1256);
      m0 = 1256;
`else
      chk("duty_plus5000", d0(), 6000);
      m0 = 6000;
`endif
      chk("duty_ch1_hold", d1(), 1000);
      drive_to(49000, 100);
      set_doff(200, -300);
      tick(1'b1, 1'b0);
      chk("duty_ceiling", d0(), 49151);
      chk("duty_floor", d1(), 0);
      m0 = 49151; m1 = 0;

      // RPM target saturation.
      base_rpm = 16'd30; set_rofs(-200, -5);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
      chk("sat_low_sp0", s0(), 0);
      chk("ofs_sp1", s1(), 25);
      base_rpm = 16'd65530; set_rofs(50, 3);
      for (int i = 0; i < 6560; i++) tick(1'b0, 1'b1);
      chk("sat_high_sp0", s0(), 65535);
      chk("sat_high_sp1", s1(), 65533);
      chk("run_retarget_state", state, 2);
      base_rpm = 16'd100; set_rofs(0, 0);
      for (int i = 0; i < 6550; i++) tick(1'b0, 1'b1);
      chk("back100_sp0", s0(), 100);
      drive_to(1000, 1000);

      // Soft stop with simultaneous strobes, then resume.
      en = 1'b0;
      step();
      chk("stop_state", state, 3);
      tick(1'b1, 1'b1);
      chk("stop1_duty0", d0(), 744);
      chk("stop1_sp1", s1(), 90);
      tick(1'b1, 1'b1);
      chk("stop2_duty1", d1(), 488);
      chk("stop2_sp0", s0(), 80);
      en = 1'b1;
      step();
      chk("resume_state", state, 1);
      chk("resume_duty", d0(), 488);
      set_doff(12, 12);
      tick(1'b1, 1'b1);
      chk("resume_duty_up", d0(), 500);
      chk("resume_sp_up", s0(), 90);

      // Stop to DISABLED.
      set_doff(0, 0);
      en = 1'b0;
      step();
      chk("stop2_state", state, 3);
      for (int i = 0; i < 9; i++) tick(1'b1, 1'b1);
      chk("zero_duty", duty_cycle, 0);
      chk("zero_sp", rpm_setpoint, 0);
      chk("zero_state_pre", state, 3);
      step();
      chk("disabled_state", state, 0);

      // Reset mid-ramp with both strobes active.
      en = 1'b1;
      step();
      set_doff(100, 100);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
      chk("mid_sp0", s0(), 30);
      chk("mid_duty1", d1(), 300);
      reset = 1'b1; clk_en_tach = 1'b1; clk_en_adc = 1'b1;
      step();
      chk("mid_rst_state", state, 0);
      chk("mid_rst_duty", duty_cycle, 0);
      chk("mid_rst_sp", rpm_setpoint, 0);
      reset = 1'b0; clk_en_tach = 1'b0; clk_en_adc = 1'b0; set_doff(0, 0);
      step();
      chk("restart_state", state, 1);
      tick(1'b0, 1'b1);
      chk("restart_sp0", s0(), 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
